barrel_normalizer: RTL and testbench



---
 rtl/barrel_normalizer.sv | 116 +++++++++++
 tb/tb_barrel_normalizer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : barrel_normalizer
// Purpose  : Multi-cycle left-shift normalizer (inverse of the barrel shifter);
//            reports the normalized value and the shift count.
// Revision : 1.0 - initial release
// ============================================================================
module barrel_normalizer #(
  parameter int W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_mode_i,
  input  logic [W-1:0]         data_in_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [W-1:0]         data_out_o,
  output logic [$clog2(W)-1:0] shift_o,
  output logic                 zero_o
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic [W-1:0]   data_out_q, data_out_d;
  logic [CW-1:0]  shift_q, shift_d;
  logic           zero_q, zero_d;

  logic           is_zero;
  logic           is_norm;
  logic           is_sat;

  assign is_zero = (work_q == '0);
  // Signed operands are normalized once the sign bit differs from the next bit.
  assign is_norm = mode_q ? (work_q[W-1] ^ work_q[W-2]) : work_q[W-1];
  assign is_sat  = (cnt_q == CW'(W - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      data_out_q <= '0;
      shift_q    <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      data_out_q <= data_out_d;
      shift_q    <= shift_d;
      zero_q     <= zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    data_out_d = data_out_q;
    shift_d    = shift_q;
    zero_d     = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          work_d  = data_in_i;
          cnt_d   = '0;
          mode_d  = signed_mode_i;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (is_zero || is_norm || is_sat) begin
          data_out_d = work_q;
          shift_d    = is_zero ? '0 : cnt_q;
          zero_d     = is_zero;
          state_d    = S_DONE;
        end else begin
          work_d = {work_q[W-2:0], 1'b0};
          cnt_d  = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign data_out_o = data_out_q;
  assign shift_o    = shift_q;
  assign zero_o     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrel_normalizer
// Purpose  : Scoreboard bench for barrel_normalizer (directed + back-to-back).
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrel_normalizer;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        signed_mode_i;
  logic [15:0] data_in_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] data_out_o;
  logic [3:0]  shift_o;
  logic        zero_o;

  barrel_normalizer #(.W(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .signed_mode_i (signed_mode_i),
    .data_in_i     (data_in_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .data_out_o    (data_out_o),
    .shift_o       (shift_o),
    .zero_o        (zero_o)
  );

  typedef struct {
    logic [15:0] din;
    logic        mode;
    logic [15:0] dout;
    logic [3:0]  sh;
    logic        z;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Independent reference: count leading zeros / redundant sign bits.
  function automatic void model(input logic [15:0] d, input logic m,
                                output logic [15:0] o, output logic [3:0] s,
                                output logic z);
    int n;
    n = 0;
    z = (d == 16'h0000);
    if (z) begin
      o = 16'h0000;
      s = 4'd0;
      return;
    end
    if (!m) begin
      for (int j = 15; j >= 0 && !d[j]; j--) n++;
    end else begin
      for (int j = 14; j >= 0 && d[j] == d[15]; j--) n++;
    end
    if (n > 15) n = 15;
    s = 4'(n);
    o = d << n;
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // where the DUT is idle again and ready for the next start.
  task automatic do_op(input logic [15:0] d, input logic m, input logic [15:0] eo,
                       input logic [3:0] es, input logic ez, input bit keep_start);
    exp_t e;
    start_i       = 1'b1;
    data_in_i     = d;
    signed_mode_i = m;
    e.din      = d;
    e.mode     = m;
    e.dout     = eo;
    e.sh       = es;
    e.z        = ez;
    e.done_cyc = cyc + 2 + int'(es);
    q.push_back(e);
    @(negedge clk_i);
    if (!keep_start) start_i = 1'b0;
    repeat (int'(es) + 2) @(negedge clk_i);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents done.
  initial begin : monitor
    exp_t        e;
    logic        prev_done;
    logic [15:0] back;
    prev_done = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_done = 1'b0;
      end else if (done_o) begin
        chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("data_out", {16'd0, data_out_o}, {16'd0, e.dout});
          chk("shift", {28'd0, shift_o}, {28'd0, e.sh});
          chk("zero", {31'd0, zero_o}, {31'd0, e.z});
          chk("latency_cycle", cyc, e.done_cyc);
          if (e.mode) back = $signed(data_out_o) >>> shift_o;
          else        back = data_out_o >> shift_o;
          chk("shift_back", {16'd0, back}, {16'd0, e.din});
        end
        prev_done = 1'b1;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [15:0] d, eo;
    logic [3:0]  es;
    logic        ez, m;
    exp_t        e;

    rst_i         = 1'b1;
    start_i       = 1'b0;
    signed_mode_i = 1'b0;
    data_in_i     = 16'h0000;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_data_out", {16'd0, data_out_o}, 32'd0);
    chk("reset_shift", {28'd0, shift_o}, 32'd0);
    chk("reset_zero", {31'd0, zero_o}, 32'd0);

    // Unsigned 0x0001 with a cycle-by-cycle busy trace.
    start_i       = 1'b1;
    data_in_i     = 16'h0001;
    signed_mode_i = 1'b0;
    e.din = 16'h0001; e.mode = 1'b0; e.dout = 16'h8000; e.sh = 4'd15; e.z = 1'b0;
    e.done_cyc = cyc + 17;
    q.push_back(e);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      chk("busy_during_op", {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
    end
    chk("busy_after_op", {31'd0, busy_o}, 32'd0);

    do_op(16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0, 1'b0);
    do_op(16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0, 1'b0);
    do_op(16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1, 1'b0);
    do_op(16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1, 1'b0);
    do_op(16'hFFF0, 1'b1, 16'h8000, 4'd11, 1'b0, 1'b0);
    do_op(16'h0003, 1'b1, 16'h6000, 4'd13, 1'b0, 1'b0);
    do_op(16'hFFFF, 1'b1, 16'h8000, 4'd15, 1'b0, 1'b0);

    // Abort by reset mid-operation; a start while busy must be ignored.
    start_i       = 1'b1;
    data_in_i     = 16'h0001;
    signed_mode_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    start_i   = 1'b1;
    data_in_i = 16'h8000;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("busy_before_abort", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_data_out", {16'd0, data_out_o}, 32'd0);
    chk("abort_shift", {28'd0, shift_o}, 32'd0);
    chk("abort_zero", {31'd0, zero_o}, 32'd0);
    repeat (20) @(negedge clk_i);
    chk("abort_stays_idle", {31'd0, busy_o}, 32'd0);
    do_op(16'h0100, 1'b0, 16'h8000, 4'd7, 1'b0, 1'b0);

    // Back-to-back with start held high the whole time.
    for (int i = 0; i < 1000; i++) begin
      m = 1'(i % 2);
      d = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if (m && $urandom_range(0, 1) == 1) d = ~d;
      model(d, m, eo, es, ez);
      do_op(d, m, eo, es, ez, 1'b1);
    end
    start_i = 1'b0;

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk_i);
    chk("scoreboard_drained", q.size(), 32'd0);
    repeat (5) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
